// File: rtl/refresh_pll_reset_seq.sv
// refresh_pll_reset_seq: pixel-clock PLL reset/lock sequencer with timeout retries,
// lock-loss tracking and a sticky fail state; every output is a registered decode of the next state.
module refresh_pll_reset_seq #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_STABLE  = 64,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int MAX_RETRIES  = 4,
  parameter int CNT_W        = 17
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       video_rst,
  output logic       ready,
  output logic       fail,
  output logic [2:0] state,
  output logic [7:0] retry_cnt,
  output logic [7:0] loss_cnt
);
  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  state_t           r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic [7:0]       r_retry, w_retry_nx, w_retry_inc;
  logic [7:0]       r_loss, w_loss_nx;
  logic             r_sync1, r_lock_s;
  logic             r_pll_rst, r_video_rst, r_ready, r_fail;

  assign w_retry_inc = (r_retry == 8'hff) ? r_retry : r_retry + 8'd1;

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_retry_nx = r_retry;
    w_loss_nx  = r_loss;
    if (relock_req) begin
      w_state_nx = S_PLL_RST;
      w_cnt_nx   = '0;
      w_retry_nx = '0;
    end else begin
      case (r_state)
        S_PLL_RST: begin
          w_state_nx = (r_cnt == CNT_W'(RST_CYCLES - 1)) ? S_WAIT_LOCK : S_PLL_RST;
          w_cnt_nx   = (r_cnt == CNT_W'(RST_CYCLES - 1)) ? '0 : r_cnt + CNT_W'(1);
        end
        S_WAIT_LOCK: begin
          // a lock seen on the timeout cycle wins over the retry
          if (r_lock_s) begin
            w_state_nx = S_STABLE;
            w_cnt_nx   = '0;
          end else if (r_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
            w_retry_nx = w_retry_inc;
            w_state_nx = (w_retry_inc == 8'(MAX_RETRIES)) ? S_FAIL : S_PLL_RST;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = r_cnt + CNT_W'(1);
          end
        end
        S_STABLE: begin
          if (!r_lock_s) begin
            w_state_nx = S_WAIT_LOCK;
            w_cnt_nx   = '0;
          end else if (r_cnt == CNT_W'(LOCK_STABLE - 1)) begin
            w_state_nx = S_RUN;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = r_cnt + CNT_W'(1);
          end
        end
        S_RUN: begin
          if (!r_lock_s) begin
            w_state_nx = S_PLL_RST;
            w_cnt_nx   = '0;
            w_loss_nx  = (r_loss == 8'hff) ? r_loss : r_loss + 8'd1;
          end
        end
        S_FAIL: w_state_nx = S_FAIL;
        default: begin
          w_state_nx = S_PLL_RST;
          w_cnt_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state     <= S_PLL_RST;
      r_cnt       <= '0;
      r_retry     <= '0;
      r_loss      <= '0;
      r_sync1     <= 1'b0;
      r_lock_s    <= 1'b0;
      r_pll_rst   <= 1'b1;
      r_video_rst <= 1'b1;
      r_ready     <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_retry     <= w_retry_nx;
      r_loss      <= w_loss_nx;
      r_sync1     <= pll_locked;
      r_lock_s    <= r_sync1;
      r_pll_rst   <= (w_state_nx == S_PLL_RST) || (w_state_nx == S_FAIL);
      r_video_rst <= (w_state_nx != S_RUN);
      r_ready     <= (w_state_nx == S_RUN);
      r_fail      <= (w_state_nx == S_FAIL);
    end
  end

  assign pll_rst   = r_pll_rst;
  assign video_rst = r_video_rst;
  assign ready     = r_ready;
  assign fail      = r_fail;
  assign state     = r_state;
  assign retry_cnt = r_retry;
  assign loss_cnt  = r_loss;
endmodule

// File: tb/tb_refresh_pll_reset_seq.sv
// tb_refresh_pll_reset_seq: vector table, lock-loss saturation and random traffic against a countdown model.
module tb_refresh_pll_reset_seq;
  localparam int RC = 4, LS = 8, LT = 32, MR = 3;

  logic       refclk = 1'b0;
  logic       rst = 1'b1, pll_locked = 1'b0, relock_req = 1'b0;
  logic       pll_rst, video_rst, ready, fail;
  logic [2:0] state;
  logic [7:0] retry_cnt, loss_cnt;

  refresh_pll_reset_seq #(
    .RST_CYCLES(RC), .LOCK_STABLE(LS), .LOCK_TIMEOUT(LT), .MAX_RETRIES(MR), .CNT_W(8)
  ) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .relock_req(relock_req),
    .pll_rst(pll_rst), .video_rst(video_rst), .ready(ready), .fail(fail),
    .state(state), .retry_cnt(retry_cnt), .loss_cnt(loss_cnt)
  );

  always #5 refclk = ~refclk;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: phase uses the spec encodings, m_rem counts down the cycles left in a timed phase,
  // and the 2-flop synchronizer is a queue of sampled lock values (decision at edge k sees edge k-2).
  int   m_ph = 0, m_rem = RC, m_rt = 0, m_ls = 0;
  int   hist[$];

  task automatic model_step(input logic r, input logic l, input logic q);
    int s;
    if (r) begin
      m_ph = 0; m_rem = RC; m_rt = 0; m_ls = 0;
      hist.delete();
      return;
    end
    s = (hist.size() >= 2) ? hist[hist.size()-2] : 0;
    hist.push_back(int'(l));
    if (hist.size() > 3) void'(hist.pop_front());
    if (q) begin
      m_ph = 0; m_rem = RC; m_rt = 0;
    end else if (m_ph == 0) begin
      m_rem -= 1;
      if (m_rem == 0) begin m_ph = 1; m_rem = LT; end
    end else if (m_ph == 1) begin
      if (s != 0) begin
        m_ph = 2; m_rem = LS;
      end else begin
        m_rem -= 1;
        if (m_rem == 0) begin
          m_rt = (m_rt < 255) ? m_rt + 1 : 255;
          m_ph = (m_rt == MR) ? 4 : 0;
          m_rem = RC;
        end
      end
    end else if (m_ph == 2) begin
      if (s == 0) begin
        m_ph = 1; m_rem = LT;
      end else begin
        m_rem -= 1;
        if (m_rem == 0) m_ph = 3;
      end
    end else if (m_ph == 3) begin
      if (s == 0) begin
        m_ph = 0; m_rem = RC;
        m_ls = (m_ls < 255) ? m_ls + 1 : 255;
      end
    end
  endtask

  task automatic tick(input logic r, input logic l, input logic q);
    rst = r; pll_locked = l; relock_req = q;
    @(posedge refclk);
    model_step(r, l, q);
    #1;
    chk("model", {9'd0, state, pll_rst, video_rst, ready, fail, retry_cnt, loss_cnt},
        {9'd0, 3'(m_ph), m_ph == 0 || m_ph == 4, m_ph != 3, m_ph == 3, m_ph == 4, 8'(m_rt), 8'(m_ls)});
  endtask

  task automatic chk_state(input string nm, input int st, input int rt, input int ls);
    chk({nm, ".state"}, 32'(state), 32'(st));
    chk({nm, ".retry"}, 32'(retry_cnt), 32'(rt));
    chk({nm, ".loss"}, 32'(loss_cnt), 32'(ls));
    chk({nm, ".pll_rst"}, 32'(pll_rst), 32'(st == 0 || st == 4));
    chk({nm, ".video_rst"}, 32'(video_rst), 32'(st != 3));
    chk({nm, ".ready"}, 32'(ready), 32'(st == 3));
    chk({nm, ".fail"}, 32'(fail), 32'(st == 4));
  endtask

  typedef struct {
    int   n;
    logic r, l, q;
    int   st, rt, ls;
  } vec_t;
  localparam int NV = 35;
  vec_t tbl[NV];

  initial begin
    logic lvl;
    int   run;
    tbl = '{
      '{1, 1'b1, 1'b0, 1'b0, 0, 0, 0},  '{3, 1'b0, 1'b0, 1'b0, 0, 0, 0},
      '{1, 1'b0, 1'b0, 1'b0, 1, 0, 0},  '{10, 1'b0, 1'b0, 1'b0, 1, 0, 0},
      '{1, 1'b0, 1'b1, 1'b0, 1, 0, 0},  '{1, 1'b0, 1'b1, 1'b0, 1, 0, 0},
      '{1, 1'b0, 1'b1, 1'b0, 2, 0, 0},  '{7, 1'b0, 1'b1, 1'b0, 2, 0, 0},
      '{1, 1'b0, 1'b1, 1'b0, 3, 0, 0},  '{2, 1'b0, 1'b0, 1'b0, 3, 0, 0},
      '{1, 1'b0, 1'b0, 1'b0, 0, 0, 1},  '{4, 1'b0, 1'b1, 1'b0, 1, 0, 1},
      '{1, 1'b0, 1'b1, 1'b0, 2, 0, 1},  '{8, 1'b0, 1'b1, 1'b0, 3, 0, 1},
      '{1, 1'b0, 1'b1, 1'b1, 0, 0, 1},  '{5, 1'b0, 1'b1, 1'b0, 2, 0, 1},
      '{1, 1'b0, 1'b1, 1'b1, 0, 0, 1},  '{4, 1'b0, 1'b0, 1'b0, 1, 0, 1},
      '{31, 1'b0, 1'b0, 1'b0, 1, 0, 1}, '{1, 1'b0, 1'b0, 1'b0, 0, 1, 1},
      '{36, 1'b0, 1'b0, 1'b0, 0, 2, 1}, '{35, 1'b0, 1'b0, 1'b0, 1, 2, 1},
      '{1, 1'b0, 1'b0, 1'b0, 4, 3, 1},  '{20, 1'b0, 1'b0, 1'b0, 4, 3, 1},
      '{1, 1'b0, 1'b0, 1'b1, 0, 0, 1},  '{10, 1'b0, 1'b0, 1'b0, 1, 0, 1},
      '{1, 1'b1, 1'b0, 1'b0, 0, 0, 0},  '{4, 1'b0, 1'b0, 1'b0, 1, 0, 0},
      '{5, 1'b0, 1'b1, 1'b0, 2, 0, 0},  '{1, 1'b0, 1'b0, 1'b0, 2, 0, 0},
      '{1, 1'b0, 1'b1, 1'b0, 2, 0, 0},  '{1, 1'b0, 1'b1, 1'b0, 1, 0, 0},
      '{1, 1'b0, 1'b1, 1'b0, 2, 0, 0},  '{7, 1'b0, 1'b1, 1'b0, 2, 0, 0},
      '{1, 1'b0, 1'b1, 1'b0, 3, 0, 0}
    };
    for (int i = 0; i < NV; i++) begin
      for (int k = 0; k < tbl[i].n; k++) tick(tbl[i].r, tbl[i].l, tbl[i].q);
      chk_state($sformatf("vec%0d", i), tbl[i].st, tbl[i].rt, tbl[i].ls);
    end
    // 260 lock losses from RUN: three edges to drop into PLL_RST, thirteen to relock
    for (int i = 0; i < 260; i++) begin
      repeat (3) tick(1'b0, 1'b0, 1'b0);
      if (i == 254) chk("sat.loss254", 32'(loss_cnt), 32'd255);
      repeat (13) tick(1'b0, 1'b1, 1'b0);
    end
    chk_state("sat", 3, 0, 255);
    tick(1'b0, 1'b1, 1'b1);
    chk_state("sat.relock", 0, 0, 255);
    tick(1'b1, 1'b0, 1'b0);
    chk_state("rand.rst", 0, 0, 0);
    lvl = 1'b0;
    run = 0;
    for (int i = 0; i < 3000; i++) begin
      if (run == 0) begin
        lvl = ~lvl;
        run = lvl ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 150));
      end
      run--;
      tick($urandom_range(0, 399) == 0, lvl, $urandom_range(0, 149) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
